inst_fetch_stage: RTL and testbench

//  Front end of the mips core. Owns the PC and drives the SRAM-like instruction port
//  (inst_req/addr_ok/data_ok). That port is served by the 1-cycle SRAM wrapper or by the AXI bridge.

---
 rtl/inst_fetch_stage_pkg.sv | 21 ++
 rtl/inst_fetch_stage_buffer.sv | 51 +++++
 rtl/inst_fetch_stage.sv | 120 ++++++++++++
 tb/tb_inst_fetch_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_stage_pkg.sv
// rtl/inst_fetch_stage_pkg.sv - shared constants, FSM encodings and buffer entry type for the fetch stage
package inst_fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [1:0]  SIZE_WORD        = 2'b10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fetch_stage_buffer.sv
// rtl/inst_fetch_stage_buffer.sv - circular FIFO holding fetched words with their PC
module fetch_buffer #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  // a push into a full buffer is fine when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush && !rst) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/inst_fetch_stage.sv
// rtl/inst_fetch_stage.sv - PC owner and instruction-port master feeding decode through a fetch buffer
module inst_fetch_stage import inst_fetch_stage_pkg::*; #(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic [31:0] inst_rdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel
);

  logic [1:0]   state;
  logic [31:0]  pc;
  logic [31:0]  issue_addr;
  logic         discard;
  logic         halted;
  logic         push;
  logic         full;
  logic         empty;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign inst_req   = (state == ST_REQ);
  assign inst_wr    = 1'b0;
  assign inst_size  = SIZE_WORD;
  assign inst_wdata = 32'd0;
  // issue_addr keeps the bus address stable even when a redirect lands in REQ
  assign inst_addr  = issue_addr;

  assign id_valid = !empty;
  assign id_pc    = head_entry.pc;
  assign id_inst  = head_entry.inst;
  assign id_adel  = head_entry.adel;

  always_comb begin
    push       = 1'b0;
    push_entry = '{pc: pc, inst: 32'd0, adel: 1'b1};
    if (!redirect_valid) begin
      if (state == ST_IDLE && !halted && !full && pc[1:0] != 2'b00) begin
        push = 1'b1;
      end else if (state == ST_WAIT && inst_data_ok && !discard) begin
        push       = 1'b1;
        push_entry = '{pc: issue_addr, inst: inst_rdata, adel: 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_PC;
      issue_addr <= RESET_PC;
      discard    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // the !full check reserves the slot the returning word will use
          if (!redirect_valid && !halted && !full) begin
            if (pc[1:0] == 2'b00) begin
              state      <= ST_REQ;
              issue_addr <= pc;
            end else begin
              halted <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (inst_addr_ok) begin
            state <= ST_WAIT;
            if (!redirect_valid && !discard) pc <= next_pc(pc);
          end
          if (redirect_valid) discard <= 1'b1;
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            state   <= ST_IDLE;
            discard <= 1'b0;
          end else if (redirect_valid) begin
            discard <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (redirect_valid) begin
        pc     <= redirect_pc;
        halted <= 1'b0;
      end
    end
  end

  fetch_buffer #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(BUF_DEPTH)
  ) u_buffer (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (id_valid && id_ready),
    .flush    (redirect_valid),
    .full     (full),
    .empty    (empty),
    .head     (head_entry)
  );

endmodule

// File: tb/tb_inst_fetch_stage.sv
// tb/tb_inst_fetch_stage.sv - randomized bench with a transaction-level fetch model and directed scenarios
module tb_inst_fetch_stage;

  localparam logic [31:0] RPC   = 32'hBFC0_0000;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        rst;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic [31:0] inst_rdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;

  inst_fetch_stage #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_pc(id_pc), .id_inst(id_inst), .id_adel(id_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction-port responder: SRAM wrapper (mode 0) or AXI-like bridge (mode 1)
  int   axi_mode = 0;
  int   alat_cfg = 0;
  int   dlat_cfg = 1;
  bit   rand_lat = 0;
  int   lat_cnt  = 0;
  bit   pend     = 0;
  int   dcnt     = 0;
  logic [31:0] paddr;

  task automatic set_bus(input int mode, input int alat, input int dlat, input bit rnd);
    axi_mode = mode;
    alat_cfg = alat;
    dlat_cfg = dlat;
    rand_lat = rnd;
    lat_cnt  = (mode != 0) ? alat : 0;
  endtask

  initial begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = 32'd0;
    forever begin
      @(negedge clk);
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      inst_rdata   = $urandom;
      if (pend) begin
        dcnt--;
        if (dcnt == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_word(paddr);
          pend         = 1'b0;
        end
      end else if (inst_req) begin
        if (axi_mode == 0 || lat_cnt <= 0) begin
          inst_addr_ok = 1'b1;
          pend         = 1'b1;
          paddr        = inst_addr;
          dcnt         = (axi_mode == 0) ? 1 : (rand_lat ? int'($urandom_range(1, 5)) : dlat_cfg);
          lat_cnt      = (axi_mode == 0) ? 0 : (rand_lat ? int'($urandom_range(0, 3)) : alat_cfg);
        end else begin
          lat_cnt--;
        end
      end
    end
  end

  // transaction-level model: what must be requested and what decode must see
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adel;
  } ent_t;

  ent_t        q[$];
  ent_t        e;
  logic [31:0] acc_q[$];
  logic [31:0] pop_q[$];
  logic [31:0] m_fetch_pc;
  logic [31:0] m_cur;
  logic [31:0] m_wait;
  bit          m_req, m_waiting, m_kill_req, m_kill, m_halted;
  bit          started = 0;
  bit          idle, pre_full;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst && inst_req && inst_addr_ok) acc_q.push_back(inst_addr);
      if (!rst && id_valid && id_ready && !redirect_valid) pop_q.push_back(id_pc);
      if (rst) begin
        q.delete();
        m_fetch_pc = RPC;
        m_req      = 0;
        m_waiting  = 0;
        m_kill     = 0;
        m_kill_req = 0;
        m_halted   = 0;
        started    = 1;
      end else begin
        idle     = !m_req && !m_waiting;
        pre_full = (q.size() >= DEPTH);
        if (q.size() > 0 && id_ready) void'(q.pop_front());
        if (m_waiting && inst_data_ok) begin
          m_waiting = 0;
          if (!m_kill && !redirect_valid) begin
            e = '{m_wait, mem_word(m_wait), 1'b0};
            q.push_back(e);
          end
          m_kill = 0;
        end else if (m_req && inst_addr_ok) begin
          m_req     = 0;
          m_waiting = 1;
          m_wait    = m_cur;
          m_kill    = m_kill_req || redirect_valid;
          if (!m_kill) m_fetch_pc = m_cur + 32'd4;
        end else if (m_waiting && redirect_valid) begin
          m_kill = 1;
        end else if (m_req && redirect_valid) begin
          m_kill_req = 1;
        end else if (idle && !redirect_valid && !m_halted && !pre_full) begin
          if (m_fetch_pc[1:0] == 2'b00) begin
            m_req      = 1;
            m_cur      = m_fetch_pc;
            m_kill_req = 0;
          end else begin
            e = '{m_fetch_pc, 32'd0, 1'b1};
            q.push_back(e);
            m_halted = 1;
          end
        end
        if (redirect_valid) begin
          q.delete();
          m_fetch_pc = redirect_pc;
          m_halted   = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        check("inst_req", 32'(inst_req), 32'(m_req));
        if (m_req) check("inst_addr", inst_addr, m_cur);
        check("id_valid", 32'(id_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
          check("id_pc", id_pc, q[0].pc);
          check("id_inst", id_inst, q[0].inst);
          check("id_adel", 32'(id_adel), 32'(q[0].adel));
        end
        check("inst_consts", {inst_wr, inst_size, inst_wdata[28:0]}, 32'h4000_0000);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    acc_q.delete();
    pop_q.delete();
    rst = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    @(negedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  function automatic int count_in(input logic [31:0] a);
    int n = 0;
    foreach (pop_q[i]) if (pop_q[i] == a) n++;
    return n;
  endfunction

  int          held;
  int          n;
  bit          found;
  logic [31:0] killed;

  initial begin
    rst            = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    set_bus(0, 0, 1, 0);
    repeat (3) @(negedge clk);
    check("reset_inst_req", 32'(inst_req), 32'd0);
    check("reset_id_valid", 32'(id_valid), 32'd0);

    // 1: sequential fetch on the SRAM wrapper
    do_reset();
    repeat (12) @(negedge clk);
    check("p1_acc_count", 32'(acc_q.size() >= 3), 32'd1);
    if (acc_q.size() >= 3) begin
      check("p1_addr0", acc_q[0], 32'hBFC0_0000);
      check("p1_addr1", acc_q[1], 32'hBFC0_0004);
      check("p1_addr2", acc_q[2], 32'hBFC0_0008);
    end
    check("p1_pop_count", 32'(pop_q.size() >= 2), 32'd1);
    if (pop_q.size() >= 2) begin
      check("p1_pop0", pop_q[0], 32'hBFC0_0000);
      check("p1_pop1", pop_q[1], 32'hBFC0_0004);
    end

    // 2: decode stalled, buffer fills, then drains
    id_ready = 1'b0;
    do_reset();
    repeat (20) @(negedge clk);
    check("p2_acc_count", 32'(acc_q.size()), 32'd2);
    check("p2_req_quiet", 32'(inst_req), 32'd0);
    check("p2_head_valid", 32'(id_valid), 32'd1);
    check("p2_head_pc", id_pc, 32'hBFC0_0000);
    check("p2_head_inst", id_inst, mem_word(32'hBFC0_0000));
    #1 id_ready = 1'b1;
    repeat (6) @(negedge clk);
    check("p2_resume", (acc_q.size() > 2) ? acc_q[2] : 32'd0, 32'hBFC0_0008);
    check("p2_pop0", (pop_q.size() > 0) ? pop_q[0] : 32'd0, 32'hBFC0_0000);

    // 3: AXI-like bridge, addr_ok 3 cycles late, data 5 cycles later
    set_bus(1, 3, 5, 0);
    do_reset();
    held = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (inst_req && !inst_addr_ok && acc_q.size() == 0) held++;
    end
    check("p3_req_held", 32'(held), 32'd3);
    check("p3_no_dup", 32'(acc_q.size()), 32'd1);
    check("p3_one_word", 32'(pop_q.size()), 32'd1);
    check("p3_word_pc", (pop_q.size() > 0) ? pop_q[0] : 32'd0, 32'hBFC0_0000);

    // 4: redirect while waiting on BFC00004
    set_bus(1, 0, 4, 0);
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (acc_q.size() == 2) found = 1;
    end
    check("p4_reached_wait", 32'(found), 32'd1);
    #1 pulse_redirect(32'h8000_1000);
    repeat (20) @(negedge clk);
    check("p4_next_addr", (acc_q.size() > 2) ? acc_q[2] : 32'd0, 32'h8000_1000);
    check("p4_no_bfc00004", 32'(count_in(32'hBFC0_0004)), 32'd0);

    // 5a: redirect coincident with addr_ok
    set_bus(0, 0, 1, 0);
    do_reset();
    repeat (4) @(negedge clk);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (inst_req && inst_addr_ok) found = 1;
    end
    check("p5a_found_req", 32'(found), 32'd1);
    killed = inst_addr;
    n = acc_q.size();
    pulse_redirect(32'h8000_2000);
    repeat (10) @(negedge clk);
    check("p5a_next_addr", (acc_q.size() > n + 1) ? acc_q[n+1] : 32'd0, 32'h8000_2000);
    check("p5a_dropped", 32'(count_in(killed)), 32'd0);

    // 5b: redirect coincident with data_ok
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      #1;
      if (inst_req && inst_addr_ok) found = 1;
    end
    killed = inst_addr;
    n = acc_q.size();
    @(negedge clk);
    #1;
    check("p5b_data_ok", 32'(found && inst_data_ok), 32'd1);
    pulse_redirect(32'h8000_3000);
    repeat (10) @(negedge clk);
    check("p5b_next_addr", (acc_q.size() > n + 1) ? acc_q[n+1] : 32'd0, 32'h8000_3000);
    check("p5b_dropped", 32'(count_in(killed)), 32'd0);

    // 6: misaligned redirect yields one address-error entry and halts fetch
    #1 id_ready = 1'b0;
    pulse_redirect(32'h8000_0002);
    repeat (3) @(negedge clk);
    n = acc_q.size();
    repeat (15) @(negedge clk);
    check("p6_quiet", 32'(acc_q.size() - n), 32'd0);
    check("p6_req", 32'(inst_req), 32'd0);
    check("p6_valid", 32'(id_valid), 32'd1);
    check("p6_adel", 32'(id_adel), 32'd1);
    check("p6_pc", id_pc, 32'h8000_0002);
    check("p6_inst", id_inst, 32'd0);
    #1 id_ready = 1'b1;
    n = acc_q.size();
    pulse_redirect(32'h8000_0000);
    repeat (6) @(negedge clk);
    check("p6_resume", (acc_q.size() > n) ? acc_q[n] : 32'd0, 32'h8000_0000);

    // random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (i % 200 == 0) set_bus(int'($urandom_range(0, 1)), 0, 1, 1);
      id_ready = ($urandom_range(0, 3) != 0);
      rst      = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        case ($urandom_range(0, 5))
          0:       redirect_pc = 32'hFFFF_FFF8;
          1:       redirect_pc = $urandom | 32'd1;
          default: redirect_pc = $urandom & 32'hFFFF_FFFC;
        endcase
      end else begin
        redirect_valid = 1'b0;
      end
    end
    @(negedge clk);
    #1;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
